pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Handshaked pipeline stage register between two LEGv8 datapath stages.
- Two-entry skid buffer: a main register drives the downstream stage; a skid register absorbs one extra word when downstream stalls.
- Sustains one transfer per cycle with a registered in_ready, so downstream stall never propagates combinationally upstream.
- Synchronous flush empties the stage on branch mispredict or exception.

Parameters:
SIZE  default `WORD (64)  data width in bits

Ports:
clk        input   1     clock, rising edge
rst_n      input   1     asynchronous active-low reset
flush      input   1     synchronous flush; empties the stage
in_valid   input   1     upstream word valid
in_ready   output  1     stage can accept a word (registered)
in_data    input   SIZE  upstream word
out_valid  output  1     out_data valid (registered)
out_ready  input   1     downstream accepts out_data
out_data   output  SIZE  word to downstream (main register)
occupancy  output  2     words held: 0, 1 or 2

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Transfer rules:
  - in_xfer = in_valid & in_ready
  - out_xfer = out_valid & out_ready
  - Both are evaluated on the rising clk edge.
- States:
  - EMPTY: occupancy 0
  - BUSY: occupancy 1, main full
  - FULL: occupancy 2, main and skid full
- Outputs per state:
  - in_ready = 1 in EMPTY and BUSY, 0 in FULL
  - out_valid = 1 in BUSY and FULL
  - Both are decoded from state registers only; no combinational path from out_ready to in_ready.
- Reset (rst_n low, asynchronous): state EMPTY; main = 0; skid = 0.
  - Consequently out_valid = 0, in_ready = 1, out_data = 0, occupancy = 0.
  - Reset deasserted mid-transfer: all held words are discarded.
- Transitions (when flush = 0):
  - EMPTY, in_xfer: main <= in_data; go BUSY. out_ready ignored.
  - EMPTY, no in_xfer: stay.
  - BUSY, in_xfer & out_xfer: main <= in_data; stay BUSY. This is the full-throughput case.
  - BUSY, in_xfer only: skid <= in_data; go FULL.
  - BUSY, out_xfer only: go EMPTY. main keeps its value; out_data holds the stale word with out_valid = 0.
  - BUSY, neither: hold.
  - FULL, out_xfer: main <= skid; go BUSY. in_valid is ignored because in_ready = 0.
  - FULL, no out_xfer: hold; out_data stable.
- Flush (flush = 1 on an edge): go EMPTY; main <= 0; skid <= 0.
  - Flush has priority over any same-cycle in_xfer, whose word is dropped.
  - A same-cycle out_xfer still counts as consumed downstream.
  - Flush in EMPTY is harmless.
- Ordering:
  - Words leave in arrival order; none are lost or duplicated except by flush or reset.
  - While out_valid = 1 and out_ready = 0, out_data must not change.
- Latency:
  - One cycle from in_xfer to out_valid in EMPTY.
  - Steady-state throughput is one word per clock.
- Protocol note: in_valid may deassert without in_xfer. The stage imposes no upstream stability requirement; it samples only on in_xfer.

Test Plan:
- Reset:
  - Stimulus: assert rst_n low asynchronously mid-cycle while FULL holding 0x11 and 0x22.
  - Required: immediately out_valid = 0, in_ready = 1, out_data = 0, occupancy = 0. After release, nothing is emitted.
- Streaming:
  - Stimulus: in_valid = 1 with data 1, 2, 3, 4, 5 on consecutive cycles, out_ready = 1 throughout.
  - Required: out_data 1, 2, 3, 4, 5 on consecutive cycles starting one cycle after the first input; in_ready stays 1; occupancy never exceeds 1.
- Stall/skid:
  - Stimulus: hold out_ready = 0 and present 0xA, 0xB, 0xC back-to-back.
  - Required:
    - 0xA and 0xB accepted; in_ready = 0 in the cycle after 0xB is accepted; 0xC is held upstream; occupancy = 2.
    - After releasing out_ready, the output sequence is 0xA, 0xB, 0xC with no gaps.
    - out_data stays 0xA throughout the stall.
- Flush:
  - Stimulus: flush in FULL (0x5, 0x6) while in_valid = 1 with 0x7.
  - Required: next cycle out_valid = 0, occupancy = 0, out_data = 0; 0x7 is not emitted.
  - Stimulus: then present 0x8.
  - Required: it is emitted next.
- Drain:
  - Stimulus: BUSY holding 0x9, out_ready = 1, in_valid = 0.
  - Required: 0x9 consumed; next cycle out_valid = 0, occupancy = 0, out_data stays 0x9.
- Random:
  - Stimulus: 10,000 cycles of random in_valid/out_ready with about 2% flush.
  - Required: a scoreboard confirms in-order delivery of every unflushed accepted word and out_data stability during stalls, with SIZE = 64 and SIZE = 32.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register between datapath stages.
// in_ready and out_valid come straight from the state register, so a downstream stall never reaches upstream combinationally.
`ifndef WORD
`define WORD 64
`endif

module pipe_skid_reg #(
  parameter int SIZE = `WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic [1:0]      occupancy
);

  // Handshake: a word moves on a rising edge when valid and ready are both 1.
  // The sender may drop valid at any time; the receiver samples only on a transfer.
  // State codes equal the number of words held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] main_q, main_d;
  logic [SIZE-1:0] skid_q, skid_d;
  logic            in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins over a same-cycle in_xfer; that word is dropped.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_xfer) begin
            // main keeps the stale word; out_valid low marks it invalid.
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: 64-bit and 32-bit instances share one stimulus stream and
// are checked against a queue model of the words the stage should be holding.
`timescale 1ns/1ps

module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready64, out_valid64;
  logic [63:0] out_data64;
  logic [1:0]  occ64;
  logic        in_ready32, out_valid32;
  logic [31:0] out_data32;
  logic [1:0]  occ32;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [63:0] last_word;
  logic [63:0] head;
  int          n;
  logic        ix, ox;

  pipe_skid_reg #(.SIZE(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
    .occupancy(occ64)
  );

  pipe_skid_reg #(.SIZE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .occupancy(occ32)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ports(input string tag, input logic ov, input logic ir,
                             input logic [63:0] od, input logic [1:0] oc);
    check({tag, "_out_valid64"}, out_valid64, ov);
    check({tag, "_in_ready64"},  in_ready64,  ir);
    check({tag, "_out_data64"},  out_data64,  od);
    check({tag, "_occ64"},       occ64,       oc);
    check({tag, "_out_valid32"}, out_valid32, ov);
    check({tag, "_in_ready32"},  in_ready32,  ir);
    check({tag, "_out_data32"},  out_data32,  od[31:0]);
    check({tag, "_occ32"},       occ32,       oc);
  endtask

  // Driver: inputs change 1ns after a rising edge and hold for the whole cycle.
  task automatic cyc(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and monitor: exp_q holds the words the stage should contain, oldest first.
  // Each falling edge compares the DUT to the queue, then applies the coming edge's transfers.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      last_word = '0;
    end else begin
      n    = exp_q.size();
      head = (n > 0) ? exp_q[0] : last_word;
      check("mon_out_valid64", out_valid64, n > 0);
      check("mon_in_ready64",  in_ready64,  n < 2);
      check("mon_occ64",       occ64,       n[1:0]);
      check("mon_out_data64",  out_data64,  head);
      check("mon_out_valid32", out_valid32, n > 0);
      check("mon_in_ready32",  in_ready32,  n < 2);
      check("mon_occ32",       occ32,       n[1:0]);
      check("mon_out_data32",  out_data32,  head[31:0]);
      ix = in_valid && (n < 2);
      ox = (n > 0) && out_ready;
      if (flush) begin
        exp_q.delete();
        last_word = '0;
      end else begin
        if (ox) last_word = exp_q.pop_front();
        if (ix) exp_q.push_back(in_data);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_ports("reset", 1'b0, 1'b1, 64'h0, 2'd0);
    rst_n = 1'b1;

    // Streaming at full throughput
    for (int i = 1; i <= 5; i++) cyc(1'b1, 64'(i), 1'b1, 1'b0);
    check_ports("stream_last", 1'b1, 1'b1, 64'h5, 2'd1);
    repeat (2) cyc(1'b0, 64'h0, 1'b1, 1'b0);

    // Stall with skid absorb
    cyc(1'b1, 64'hA, 1'b0, 1'b0);
    cyc(1'b1, 64'hB, 1'b0, 1'b0);
    check_ports("stall_full", 1'b1, 1'b0, 64'hA, 2'd2);
    repeat (3) cyc(1'b1, 64'hC, 1'b0, 1'b0);
    check_ports("stall_hold", 1'b1, 1'b0, 64'hA, 2'd2);
    cyc(1'b1, 64'hC, 1'b1, 1'b0);
    check_ports("release_b", 1'b1, 1'b1, 64'hB, 2'd1);
    cyc(1'b1, 64'hC, 1'b1, 1'b0);
    check_ports("release_c", 1'b1, 1'b1, 64'hC, 2'd1);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush in FULL with a word offered on the same edge
    cyc(1'b1, 64'h5, 1'b0, 1'b0);
    cyc(1'b1, 64'h6, 1'b0, 1'b0);
    cyc(1'b1, 64'h7, 1'b0, 1'b1);
    check_ports("flush", 1'b0, 1'b1, 64'h0, 2'd0);
    cyc(1'b1, 64'h8, 1'b0, 1'b0);
    check_ports("after_flush", 1'b1, 1'b1, 64'h8, 2'd1);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    // Drain leaves the stale word visible
    cyc(1'b1, 64'h9, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    check_ports("drain", 1'b0, 1'b1, 64'h9, 2'd0);

    // Asynchronous reset mid-cycle while FULL
    cyc(1'b1, 64'h11, 1'b0, 1'b0);
    cyc(1'b1, 64'h22, 1'b0, 1'b0);
    check_ports("pre_reset", 1'b1, 1'b0, 64'h11, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_ports("async_reset", 1'b0, 1'b1, 64'h0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0);
    check_ports("post_reset", 1'b0, 1'b1, 64'h0, 2'd0);

    // Random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 99) < 65), {$urandom, $urandom},
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 2));
    end
    repeat (4) cyc(1'b0, 64'h0, 1'b1, 1'b0);
    check("final_queue_empty", 64'(exp_q.size()), 64'h0);
    check_ports("final", 1'b0, 1'b1, last_word, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
